// File: rtl/adder_pkg.sv
// adder_pkg: state encoding, default width and counter sizing
// shared by the bit-serial adder files.
package adder_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int cnt_bits(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: one-bit full adder from two half-adder
// stages and an OR, used once per serial step.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s1;
   logic c1;
   logic c2;

   assign s1   = a ^ b;
   assign c1   = a & b;
   assign s    = s1 ^ cin;
   assign c2   = s1 & cin;
   assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder with start/busy/done.
// Define SERIAL_ADD_SUB_EN to add the sub port (a-b as a+~b+1).
module serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_bits(WIDTH);

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] sha;
   logic [WIDTH-1:0] shb;
   logic [WIDTH-2:0] shs;
   logic [WIDTH-1:0] shs_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s;
   logic             c;
   logic             load;
   logic             step;
   logic             last;
   logic [WIDTH-1:0] b_ld;
   logic             cin_ld;

`ifdef SERIAL_ADD_SUB_EN
   assign b_ld   = sub ? ~b : b;
   assign cin_ld = sub;
`else
   assign b_ld   = b;
   assign cin_ld = 1'b0;
`endif

   serial_fa_cell u_fa (
      .a    (sha[0]),
      .b    (shb[0]),
      .cin  (carry),
      .s    (s),
      .cout (c)
   );

   assign load    = (state == IDLE) && start;
   assign step    = (state == RUN);
   assign last    = (cnt == CW'(WIDTH - 1));
   // shs keeps only the upper bits; the newest bit lands on top
   assign shs_nxt = {s, shs};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = start ? RUN : IDLE;
         RUN:     nxt = last ? DONE : RUN;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sha   <= '0;
         shb   <= '0;
         shs   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (1'b1)
            load: begin
               sha   <= a;
               shb   <= b_ld;
               carry <= cin_ld;
               cnt   <= '0;
            end
            step: begin
               sha   <= sha >> 1;
               shb   <= shb >> 1;
               shs   <= shs_nxt[WIDTH-1:1];
               carry <= c;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum  <= shs_nxt;
                  cout <= c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vectors plus a cycle-level
// arithmetic model checked against the DUT on every negedge.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ndone = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // model: ph=0 idle, 1..W busy, W+1 done cycle
   int           ph = 0;
   logic [W-1:0] m_sum;
   logic         m_cout;
   logic [W-1:0] p_sum;
   logic         p_cout;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph     <= 0;
         m_sum  <= '0;
         m_cout <= 1'b0;
      end else if (ph == 0) begin
         if (start) begin
            ph <= 1;
`ifdef SERIAL_ADD_SUB_EN
            if (sub)
               {p_cout, p_sum} <= {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            else
`endif
               {p_cout, p_sum} <= {1'b0, a} + {1'b0, b};
         end
      end else if (ph == W) begin
         ph     <= W + 1;
         m_sum  <= p_sum;
         m_cout <= p_cout;
      end else if (ph == W + 1) begin
         ph <= 0;
      end else begin
         ph <= ph + 1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      chk("busy", {31'b0, busy}, {31'b0, (ph >= 1 && ph <= W)});
      chk("done", {31'b0, done}, {31'b0, (ph == W + 1)});
      chk("sum", {24'b0, sum}, {24'b0, m_sum});
      chk("cout", {31'b0, cout}, {31'b0, m_cout});
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) ndone <= ndone + 1;
   end

   // called at posedge+2; returns at posedge+2 with DUT idle
   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                     input logic ts, input logic [W-1:0] es,
                     input logic ec);
      int n;
      int bc;
      bit seen;
      start = 1'b1;
      a     = ta;
      b     = tb2;
      sub   = ts;
      n     = 0;
      bc    = 0;
      seen  = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #2;
         start = 1'b0;
         a     = ~ta;
         b     = W'($urandom);
         sub   = ~ts;
         n++;
         if (done) seen = 1;
         else if (busy) bc++;
      end
      chk("latency", n, W + 1);
      chk("busy_cycles", bc, W);
      chk("sum_lit", {24'b0, sum}, {24'b0, es});
      chk("cout_lit", {31'b0, cout}, {31'b0, ec});
      @(posedge clk); #2;
   endtask

   initial begin
      int n0;
      int prev;
      int nb;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      sub   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_sum", {24'b0, sum}, 0);
      chk("rst_cout", {31'b0, cout}, 0);
      rst = 1'b0;
      @(posedge clk); #2;

      op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
      op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

      // second start 3 cycles into RUN must be dropped
      n0    = ndone;
      start = 1'b1;
      a     = 8'h35;
      b     = 8'h4A;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #2; end
      start = 1'b1;
      a     = 8'h00;
      b     = 8'h00;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (12) begin @(posedge clk); #2; end
      chk("ignored_start_dones", ndone - n0, 1);
      chk("ignored_start_sum", {24'b0, sum}, 32'h7F);

      // abort 4 cycles into RUN
      start = 1'b1;
      a     = 8'h35;
      b     = 8'h4A;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #2; end
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_done", {31'b0, done}, 0);
      chk("abort_sum", {24'b0, sum}, 0);
      chk("abort_cout", {31'b0, cout}, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      n0  = ndone;
      repeat (12) begin @(posedge clk); #2; end
      chk("abort_no_done", ndone - n0, 0);
      op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);

      // start held high: one result every W+2 cycles
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h02;
      prev  = -1;
      nb    = 0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #2;
         if (done) begin
            nb++;
            chk("b2b_sum", {24'b0, sum}, 32'h03);
            if (prev >= 0) chk("b2b_spacing", cyc - prev, W + 2);
            prev = cyc;
         end
      end
      start = 1'b0;
      chk("b2b_count", nb, 3);
      repeat (12) begin @(posedge clk); #2; end

`ifdef SERIAL_ADD_SUB_EN
      op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
      op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
